switch_bus_wrapper: RTL

Memory-mapped input peripheral for the 8-bit microprocessor bus. The processor reads board switches and push-buttons through it, where the LED wrapper is write-only. It synchronises and debounces 16 slide switches and 5 push-buttons, and latches button-press events into sticky flags. It raises a bus interrupt on each new press event and releases the interrupt on acknowledge.

---
 rtl/switch_bus_wrapper_if.sv | 21 ++
 rtl/switch_bus_wrapper.sv | 124 ++++++++++++
 2 files changed

// File: rtl/switch_bus_wrapper_if.sv
// rtl/switch_bus_wrapper_if.sv - processor bus address/control and interrupt signals for the switch peripheral
interface switch_bus_wrapper_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/switch_bus_wrapper.sv
// rtl/switch_bus_wrapper.sv - debounced switch/button input peripheral with sticky press flags and interrupt
module switch_bus_wrapper #(
  parameter logic [7:0]  SwitchBaseAddr = 8'hD0,
  parameter int unsigned DebounceCycles = 1000000
) (
  input  logic                CLK,
  input  logic                RESET,
  inout  wire  [7:0]          BUS_DATA,
  switch_bus_wrapper_if.slave bus,
  input  logic [15:0]         SWITCHES,
  input  logic [4:0]          BUTTONS
);
  localparam int          NumIn   = 21;
  localparam logic [19:0] CntLast = 20'(DebounceCycles - 1);

  typedef enum logic {IDLE, RAISED} irq_state_t;

  // Bit layout of every 21-bit input vector: [20:16] buttons, [15:0] switches.
  logic [NumIn-1:0] sync_1, sync_2, deb, deb_next;
  logic [19:0]      cnt      [NumIn];
  logic [19:0]      cnt_next [NumIn];
  logic [4:0]       evt, evt_next, btn_rise, evt_set, evt_clr;
  logic [7:0]       dout, rd_val;
  logic             drive;
  logic             addr_hit, rd_req, wr_evt;
  logic [1:0]       offset;
  irq_state_t       state, state_next;

  // Only the low five data bits carry clear requests.
  wire unused_data = &{1'b0, BUS_DATA[7:5]};

  // Decode the four-address window and classify the bus cycle.
  always_comb begin
    addr_hit = ({1'b0, bus.BUS_ADDR} >= {1'b0, SwitchBaseAddr}) &&
               ({1'b0, bus.BUS_ADDR} <= ({1'b0, SwitchBaseAddr} + 9'd3));
    offset   = 2'(bus.BUS_ADDR - SwitchBaseAddr);
    rd_req   = addr_hit && !bus.BUS_WE;
    wr_evt   = addr_hit && bus.BUS_WE && (offset == 2'd3);
  end

  // Two-stage synchroniser for the raw asynchronous levels.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {BUTTONS, SWITCHES};
      sync_2 <= sync_1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level once the count completes.
  always_comb begin
    deb_next = deb;
    for (int i = 0; i < NumIn; i++) begin
      cnt_next[i] = '0;
      if (sync_2[i] != deb[i]) begin
        if (cnt[i] == CntLast) deb_next[i] = sync_2[i];
        else                   cnt_next[i] = cnt[i] + 20'd1;
      end
    end
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      deb <= '0;
      for (int i = 0; i < NumIn; i++) cnt[i] <= '0;
    end else begin
      deb <= deb_next;
      for (int i = 0; i < NumIn; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Press detection and write-1-to-clear with set taking priority.
  always_comb begin
    btn_rise = deb_next[20:16] & ~deb[20:16];
    evt_set  = btn_rise & ~evt;
    evt_clr  = wr_evt ? BUS_DATA[4:0] : 5'd0;
    evt_next = (evt & ~evt_clr) | btn_rise;
  end

  // Register read multiplexer; reflects state before this edge's updates.
  always_comb begin
    rd_val = 8'h00;
    case (offset)
      2'd0:    rd_val = deb[7:0];
      2'd1:    rd_val = deb[15:8];
      2'd2:    rd_val = {3'b000, deb[20:16]};
      default: rd_val = {3'b000, evt};
    endcase
  end

  // Sticky flags and the one-cycle read response register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      evt   <= '0;
      dout  <= '0;
      drive <= 1'b0;
    end else begin
      evt   <= evt_next;
      drive <= rd_req;
      if (rd_req) dout <= rd_val;
    end
  end

  // Interrupt state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Raise on any new flag; an acknowledge only lowers when no new flag arrives with it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (|evt_set) state_next = RAISED;
      RAISED: if (bus.BUS_INTERRUPT_ACK && !(|evt_set)) state_next = IDLE;
    endcase
  end

  assign bus.BUS_INTERRUPT_RAISE = (state == RAISED);
  assign BUS_DATA                = drive ? dout : 8'hzz;
endmodule
